// File: rtl/run_detector_pkg.sv
// run_detector_pkg
// Shared constants for the run detector family. Lab top-levels that place
// several detectors side by side import this package so that they all agree
// on the default run length and counter width.
//
// Contents:
//   DEFAULT_RUN_LEN  default number of identical bits that counts as a run
//   DEFAULT_CNT_W    default width of the run counter
//   max_cnt()        saturation value of a counter of a given width
//   run_phase_e      documentation view of the detector state
package run_detector_pkg;

  localparam int DEFAULT_RUN_LEN = 4;
  localparam int DEFAULT_CNT_W   = 4;

  // Largest value a CNT_W-bit counter can hold; the run counter sticks here.
  function automatic int max_cnt(input int width);
    return (1 << width) - 1;
  endfunction

  // The detector is built as a counter, but it is easiest to reason about as
  // three phases, each qualified by the polarity held in last_bit:
  //   RD_IDLE  cnt == 0
  //   RD_RUN   1 <= cnt < RUN_LEN
  //   RD_DET   cnt >= RUN_LEN
  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_RUN  = 2'd1,
    RD_DET  = 2'd2
  } run_phase_e;

endpackage

// File: rtl/run_detector_sat_counter.sv
// sat_counter
// Saturating up-counter used as the run-length register of run_detector.
// It can be cleared, loaded with 1 (start of a new run) or incremented; once
// it reaches its all-ones value it holds there instead of wrapping.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (q -> 0)
//   clr    synchronous clear, highest priority
//   load1  load the value 1, beats inc
//   inc    increment, holding at the maximum value
//   q      counter value
module sat_counter
  import run_detector_pkg::*;
#(
  parameter int W = DEFAULT_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load1,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_Q = W'(max_cnt(W));

  // Priority: clear, then start-of-run load, then saturating increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load1) begin
      q <= W'(1);
    end else if (inc && (q != MAX_Q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/run_detector.sv
// run_detector
// Detects a run of RUN_LEN or more consecutive identical bits on the serial
// input w. Each bit is qualified by w_valid, so gaps in the bit stream never
// break a run. Runs of zeros and runs of ones can be enabled independently.
// The current run length is exposed, saturating at 2**CNT_W - 1.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   w          serial data bit
//   w_valid    w is sampled only on edges where this is 1
//   clear      synchronous run restart, beats w_valid
//   en_zero    enable detection of runs of 0s
//   en_one     enable detection of runs of 1s
//   out        level: run length >= RUN_LEN and its polarity is enabled
//   out_val    polarity of the current run (meaningful when run_cnt != 0)
//   det_pulse  one-cycle pulse when the run length first reaches RUN_LEN
//   run_cnt    current run length, saturating
module run_detector
  import run_detector_pkg::*;
#(
  parameter int RUN_LEN = DEFAULT_RUN_LEN,
  parameter int CNT_W   = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic             w_valid,
  input  logic             clear,
  input  logic             en_zero,
  input  logic             en_one,
  output logic             out,
  output logic             out_val,
  output logic             det_pulse,
  output logic [CNT_W-1:0] run_cnt
);

  localparam int MAX_CNT = max_cnt(CNT_W);

  // A run of one bit is not a run, and a threshold above the saturation value
  // could never be reached; refuse to build either.
  if ((RUN_LEN < 2) || (RUN_LEN > MAX_CNT)) begin : g_bad_run_len
    $fatal(1, "run_detector: RUN_LEN=%0d outside legal range 2..%0d",
           RUN_LEN, MAX_CNT);
  end

  localparam logic [CNT_W-1:0] RUN_THR = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] RUN_PRE = CNT_W'(RUN_LEN - 1);

  logic [CNT_W-1:0] cnt;
  logic             last_bit;
  logic             sample;
  logic             start_run;
  logic             extend_run;
  logic             en_for_w;
  logic             en_for_run;

  // A bit is taken only when valid and not overridden by a clear. It either
  // starts a new run (idle, or polarity changed) or extends the current one.
  assign sample     = w_valid && !clear;
  assign start_run  = sample && ((cnt == '0) || (w != last_bit));
  assign extend_run = sample && (cnt != '0) && (w == last_bit);

  // Enable seen by the incoming bit (for the pulse) and by the stored run
  // (for the level output, so enable changes show up without a new sample).
  assign en_for_w   = w ? en_one : en_zero;
  assign en_for_run = last_bit ? en_one : en_zero;

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .load1 (start_run),
    .inc   (extend_run),
    .q     (cnt)
  );

  // last_bit only changes when a new run begins; clear leaves it alone since
  // cnt == 0 already forces the next valid bit to start afresh. The pulse is
  // raised only on the step from RUN_LEN-1 to RUN_LEN, so a saturated or
  // longer run never pulses again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_bit  <= 1'b0;
      det_pulse <= 1'b0;
    end else begin
      det_pulse <= extend_run && (cnt == RUN_PRE) && en_for_w;
      if (start_run) begin
        last_bit <= w;
      end
    end
  end

  assign out     = (cnt >= RUN_THR) && en_for_run;
  assign out_val = last_bit;
  assign run_cnt = cnt;

endmodule

// File: tb/tb_run_detector.sv
// tb_run_detector
// Scoreboard bench for run_detector. Two instances share the same stimulus:
// the default build (RUN_LEN=4, CNT_W=4) and a narrow build (RUN_LEN=4,
// CNT_W=3) used to exercise saturation. A small behavioural model predicts
// the post-edge state when each bit is driven; the prediction is queued and
// popped for comparison one time unit after the clock edge.
module tb_run_detector;
  import run_detector_pkg::*;

  typedef struct {
    int   cnt;
    logic last;
    logic pulse;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       w;
  logic       w_valid;
  logic       clear;
  logic       en_zero;
  logic       en_one;
  logic       out, out_val, det_pulse;
  logic [3:0] run_cnt;
  logic       out3, out_val3, det_pulse3;
  logic [2:0] run_cnt3;

  int   tests_run    = 0;
  int   tests_failed = 0;
  exp_t sb4[$];
  exp_t sb3[$];
  int   m4_cnt  = 0;
  int   m3_cnt  = 0;
  logic m4_last = 1'b0;
  logic m3_last = 1'b0;

  always #5 clk = ~clk;

  run_detector dut (
    .clk       (clk),
    .reset     (reset),
    .w         (w),
    .w_valid   (w_valid),
    .clear     (clear),
    .en_zero   (en_zero),
    .en_one    (en_one),
    .out       (out),
    .out_val   (out_val),
    .det_pulse (det_pulse),
    .run_cnt   (run_cnt)
  );

  run_detector #(.RUN_LEN(4), .CNT_W(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .w         (w),
    .w_valid   (w_valid),
    .clear     (clear),
    .en_zero   (en_zero),
    .en_one    (en_one),
    .out       (out3),
    .out_val   (out_val3),
    .det_pulse (det_pulse3),
    .run_cnt   (run_cnt3)
  );

  // Reference behaviour of one clock edge, threshold fixed at 4.
  function automatic exp_t model_step(int cnt, logic last, int maxc,
                                      logic bw, logic bv, logic bc,
                                      logic ez, logic eo);
    exp_t e;
    e.cnt   = cnt;
    e.last  = last;
    e.pulse = 1'b0;
    if (bc) begin
      e.cnt = 0;
    end else if (bv) begin
      if (cnt == 0 || bw != last) begin
        e.cnt  = 1;
        e.last = bw;
      end else begin
        e.cnt   = (cnt == maxc) ? maxc : cnt + 1;
        e.pulse = (cnt == 3) && (bw ? eo : ez);
      end
    end
    return e;
  endfunction

  function automatic logic exp_out(exp_t e);
    return (e.cnt >= 4) && (e.last ? en_one : en_zero);
  endfunction

  // Drive one cycle of stimulus, queue the predictions, wait past the edge.
  task automatic drive_bit(input logic bw, input logic bv, input logic bc);
    exp_t e4, e3;
    w       = bw;
    w_valid = bv;
    clear   = bc;
    e4 = model_step(m4_cnt, m4_last, 15, bw, bv, bc, en_zero, en_one);
    e3 = model_step(m3_cnt, m3_last, 7, bw, bv, bc, en_zero, en_one);
    sb4.push_back(e4);
    sb3.push_back(e3);
    m4_cnt = e4.cnt; m4_last = e4.last;
    m3_cnt = e3.cnt; m3_last = e3.last;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m4_cnt = 0; m4_last = 1'b0;
    m3_cnt = 0; m3_last = 1'b0;
    sb4.delete();
    sb3.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0; w = 1'b0; w_valid = 1'b0; clear = 1'b0;
    en_zero = 1'b1; en_one = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({out, det_pulse, out_val, run_cnt} !== 7'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_state: got out=%b pulse=%b val=%b cnt=%0d expected all 0",
               out, det_pulse, out_val, run_cnt);
    end
    reset = 1'b1;
  endtask

  task automatic test_zero_run();
    exp_t e, e3;
    for (int i = 0; i < 4; i++) begin
      drive_bit(1'b0, 1'b1, 1'b0);
      e = sb4.pop_front(); e3 = sb3.pop_front();
      tests_run++;
      if (out !== (i == 3) || det_pulse !== (i == 3) || run_cnt !== 4'(i + 1)) begin
        tests_failed++;
        $display("[TB] FAIL zero_run[%0d]: got out=%b pulse=%b cnt=%0d expected out=%b pulse=%b cnt=%0d",
                 i, out, det_pulse, run_cnt, (i == 3), (i == 3), i + 1);
      end
    end
    tests_run++;
    if (out_val !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_run_val: got %b expected 0", out_val);
    end
    drive_bit(1'b0, 1'b0, 1'b0);
    e = sb4.pop_front(); e3 = sb3.pop_front();
    tests_run++;
    if (det_pulse !== 1'b0 || out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL zero_run_hold: got pulse=%b out=%b expected pulse=0 out=1",
               det_pulse, out);
    end
  endtask

  task automatic test_one_groups();
    logic pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_t e, e3;
    en_one = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_bit(pat[i], 1'b1, 1'b0);
      e = sb4.pop_front(); e3 = sb3.pop_front();
      tests_run++;
      if (run_cnt !== 4'(e.cnt) || out !== exp_out(e) || det_pulse !== e.pulse ||
          out_val !== e.last) begin
        tests_failed++;
        $display("[TB] FAIL one_groups[%0d]: got cnt=%0d out=%b pulse=%b val=%b expected cnt=%0d out=%b pulse=%b val=%b",
                 i, run_cnt, out, det_pulse, out_val, e.cnt, exp_out(e), e.pulse, e.last);
      end
    end
    tests_run++;
    if (det_pulse !== 1'b1 || run_cnt !== 4'd4) begin
      tests_failed++;
      $display("[TB] FAIL one_groups_det: got pulse=%b cnt=%0d expected pulse=1 cnt=4",
               det_pulse, run_cnt);
    end
  endtask

  task automatic test_gap();
    logic bw [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic bv [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int   cexp [7] = '{1, 2, 2, 2, 2, 3, 4};
    exp_t e, e3;
    drive_bit(1'b0, 1'b1, 1'b1);
    e = sb4.pop_front(); e3 = sb3.pop_front();
    for (int i = 0; i < 7; i++) begin
      drive_bit(bw[i], bv[i], 1'b0);
      e = sb4.pop_front(); e3 = sb3.pop_front();
      tests_run++;
      if (run_cnt !== 4'(cexp[i]) || out !== (i == 6) || det_pulse !== (i == 6)) begin
        tests_failed++;
        $display("[TB] FAIL gap[%0d]: got cnt=%0d out=%b pulse=%b expected cnt=%0d out=%b pulse=%b",
                 i, run_cnt, out, det_pulse, cexp[i], (i == 6), (i == 6));
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e, e3;
    int   pulses = 0;
    drive_bit(1'b1, 1'b1, 1'b1);
    e = sb4.pop_front(); e3 = sb3.pop_front();
    for (int i = 0; i < 10; i++) begin
      drive_bit(1'b0, 1'b1, 1'b0);
      e = sb4.pop_front(); e3 = sb3.pop_front();
      if (det_pulse3) pulses++;
      tests_run++;
      if (run_cnt3 !== 3'(e3.cnt) || out3 !== exp_out(e3) || det_pulse3 !== e3.pulse) begin
        tests_failed++;
        $display("[TB] FAIL sat[%0d]: got cnt=%0d out=%b pulse=%b expected cnt=%0d out=%b pulse=%b",
                 i, run_cnt3, out3, det_pulse3, e3.cnt, exp_out(e3), e3.pulse);
      end
    end
    tests_run++;
    if (run_cnt3 !== 3'd7 || out3 !== 1'b1 || pulses != 1) begin
      tests_failed++;
      $display("[TB] FAIL sat_final: got cnt=%0d out=%b pulses=%0d expected cnt=7 out=1 pulses=1",
               run_cnt3, out3, pulses);
    end
  endtask

  task automatic test_async_reset();
    exp_t e, e3;
    drive_bit(1'b1, 1'b1, 1'b1);
    e = sb4.pop_front(); e3 = sb3.pop_front();
    for (int i = 0; i < 3; i++) begin
      drive_bit(1'b1, 1'b1, 1'b0);
      e = sb4.pop_front(); e3 = sb3.pop_front();
    end
    tests_run++;
    if (run_cnt !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL arst_pre: got cnt=%0d expected 3", run_cnt);
    end
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (run_cnt !== 4'd0 || out !== 1'b0 || run_cnt3 !== 3'd0 || out_val !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL arst_now: got cnt=%0d out=%b cnt3=%0d val=%b expected 0 0 0 0",
               run_cnt, out, run_cnt3, out_val);
    end
    #1;
    reset = 1'b1;
    drive_bit(1'b1, 1'b1, 1'b0);
    e = sb4.pop_front(); e3 = sb3.pop_front();
    tests_run++;
    if (run_cnt !== 4'd1) begin
      tests_failed++;
      $display("[TB] FAIL arst_restart: got cnt=%0d expected 1", run_cnt);
    end
  endtask

  task automatic test_clear();
    exp_t e, e3;
    drive_bit(1'b1, 1'b1, 1'b0);
    e = sb4.pop_front(); e3 = sb3.pop_front();
    drive_bit(1'b1, 1'b1, 1'b1);
    e = sb4.pop_front(); e3 = sb3.pop_front();
    tests_run++;
    if (run_cnt !== 4'd0 || out !== 1'b0 || det_pulse !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clear: got cnt=%0d out=%b pulse=%b expected 0 0 0",
               run_cnt, out, det_pulse);
    end
  endtask

  task automatic test_enable();
    exp_t e, e3;
    int   pulses = 0;
    en_one = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_bit(1'b1, 1'b1, 1'b0);
      e = sb4.pop_front(); e3 = sb3.pop_front();
      if (det_pulse) pulses++;
    end
    tests_run++;
    if (out !== 1'b0 || pulses != 0 || run_cnt !== 4'd5) begin
      tests_failed++;
      $display("[TB] FAIL en_off: got out=%b pulses=%0d cnt=%0d expected out=0 pulses=0 cnt=5",
               out, pulses, run_cnt);
    end
    en_one = 1'b1;
    #1;
    tests_run++;
    if (out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL en_on_level: got out=%b expected 1", out);
    end
    drive_bit(1'b1, 1'b0, 1'b0);
    e = sb4.pop_front(); e3 = sb3.pop_front();
    tests_run++;
    if (det_pulse !== 1'b0 || out !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL en_on_pulse: got pulse=%b out=%b expected pulse=0 out=1",
               det_pulse, out);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e, e3;
    logic bw = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        en_zero = 1'($urandom_range(0, 1));
        en_one  = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 4) == 0) bw = ~bw;
      drive_bit(bw, ($urandom_range(0, 4) != 0), ($urandom_range(0, 30) == 0));
      e = sb4.pop_front(); e3 = sb3.pop_front();
      tests_run++;
      if (run_cnt !== 4'(e.cnt) || out !== exp_out(e) || det_pulse !== e.pulse ||
          out_val !== e.last) begin
        tests_failed++;
        $display("[TB] FAIL b2b[%0d]: got cnt=%0d out=%b pulse=%b val=%b expected cnt=%0d out=%b pulse=%b val=%b",
                 i, run_cnt, out, det_pulse, out_val, e.cnt, exp_out(e), e.pulse, e.last);
      end
      tests_run++;
      if (run_cnt3 !== 3'(e3.cnt) || out3 !== exp_out(e3) || det_pulse3 !== e3.pulse ||
          out_val3 !== e3.last) begin
        tests_failed++;
        $display("[TB] FAIL b2b3[%0d]: got cnt=%0d out=%b pulse=%b val=%b expected cnt=%0d out=%b pulse=%b val=%b",
                 i, run_cnt3, out3, det_pulse3, out_val3, e3.cnt, exp_out(e3), e3.pulse, e3.last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_run();
    test_one_groups();
    test_gap();
    test_saturation();
    test_async_reset();
    test_clear();
    test_enable();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
